coin_accumulator: RTL and testbench
===================================

// Module: coin_accumulator
// PURPOSE
// - Upstream stage of the vending controller. Turns coin-acceptor strobes into a
//   running credit value (o_credit feeds the controller's money input).
// - Owns the credit: caps it, rejects overflowing/invalid coins, refunds on request
//   or inactivity timeout, and clears it when downstream consumes it.
// PARAMETERS
// - MAX_CREDIT      60    highest credit held; coin that would exceed it is rejected
// - TIMEOUT_CYCLES  1000  COLLECT cycles with no accepted coin before auto-refund (>=2)
// - TMR_W           10    timer width; must satisfy 2**TMR_W >= TIMEOUT_CYCLES
// PORTS
// - i_clk           in   1  clock, rising edge
// - i_resetn        in   1  reset, asynchronous, active-low
// - i_coin_valid    in   1  one-cycle coin strobe
// - i_coin          in   2  coin code: 00 invalid, 01=5, 10=10, 11=25
// - i_refund        in   1  user refund request (level, sampled each cycle)
// - i_consume       in   1  downstream took the credit; clear it
// - o_credit        out  6  current credit, registered
// - o_credit_valid  out  1  1 while state==COLLECT
// - o_coin_reject   out  1  one-cycle pulse, cycle after a rejected strobe
// - o_refund_valid  out  1  one-cycle pulse while state==REFUND
// - o_refund_amt    out  6  credit being returned; 0 when o_refund_valid=0
// BEHAVIOUR
// - Reset (async, immediate): state IDLE, credit 0, timer 0, all outputs 0.
//   Reset mid-operation discards credit; no refund pulse is generated.
// - States: IDLE (credit 0), COLLECT (credit>0), REFUND (one cycle). Moore outputs.
// - Coin sum in 7 bits: accept iff strobe, code!=00, state in {IDLE,COLLECT},
//   no i_consume this cycle, and credit+value <= MAX_CREDIT. Otherwise reject.
// - Accepted coin: credit updates at next edge; IDLE->COLLECT; timer cleared.
// - Rejected strobe (incl. any strobe in REFUND): credit unchanged, reject pulse.
// - COLLECT priority per cycle: i_consume > i_refund > coin > timeout.
//   - i_consume: credit->0, next IDLE; simultaneous coin rejected.
//   - i_refund: next REFUND; simultaneous coin rejected (not added to refund).
//   - timer increments each COLLECT cycle without accepted coin; when timer ==
//     TIMEOUT_CYCLES-1 -> REFUND next edge (REFUND entered TIMEOUT_CYCLES edges
//     after the accepting edge).
// - REFUND: o_refund_valid=1, o_refund_amt=credit for exactly one cycle; next IDLE
//   with credit 0, timer 0. i_consume/i_refund ignored in REFUND.
// - IDLE: i_refund and i_consume ignored; timer held at 0.
// - o_credit_valid falls the same cycle state leaves COLLECT.
// - Credit never exceeds MAX_CREDIT, never wraps; o_credit is 6-bit unsigned.
// STRUCTURE
// - Shared package vm_pkg: MONEY_W=6, coin code localparams (COIN_NONE/5/10/25),
//   coin value lookup function, accumulator state encoding.
// - One sub-module: vm_idle_timer (clear, enable, terminal-count flag at
//   TIMEOUT_CYCLES-1); rest is FSM + credit register in this module.
// TESTING (TIMEOUT_CYCLES=8 unless stated)
// - Reset, coins 10,25,25 on separate cycles -> o_credit 10,35,60; o_credit_valid
//   rises after first coin, no reject pulses.
// - Credit 60, coin 5 -> o_coin_reject pulse next cycle, credit stays 60; code 00
//   strobe at credit 10 -> reject, credit 10.
// - Credit 35, i_refund 1 cycle -> next cycle o_refund_valid=1, o_refund_amt=35;
//   following cycle IDLE, o_credit 0, o_credit_valid 0.
// - Coin 10 then idle -> refund pulse with amt 10 exactly 8 edges after accept;
//   coin inserted at timer=6 restarts count, no refund at original deadline.
// - Credit 25, i_consume + coin 10 same cycle -> credit 0, IDLE, reject pulse,
//   no refund pulse.
// - Credit 25, i_resetn low mid-COLLECT -> all outputs 0 immediately (no clock
//   edge needed); no refund pulse after release.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: money width, coin codes, coin values
// and the coin accumulator state encoding.
package vm_pkg;

  localparam int MONEY_W = 6;
  localparam int SUM_W   = MONEY_W + 1;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_REFUND  = 2'b10
  } acc_state_t;

  // Face value of a coin code; the invalid code is worth nothing.
  function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] code);
    logic [MONEY_W-1:0] value;
    case (code)
      COIN_5:  value = 6'd5;
      COIN_10: value = 6'd10;
      COIN_25: value = 6'd25;
      default: value = 6'd0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/vm_idle_timer.sv
// Inactivity counter for the coin accumulator; flags the last idle cycle
// before an automatic refund.
module vm_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 10
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [TMR_W-1:0] count_r;

  // Idle count register; clear takes priority over counting.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      count_r <= {TMR_W{1'b0}};
    end else if (clear) begin
      count_r <= {TMR_W{1'b0}};
    end else if (enable) begin
      count_r <= count_r + {{(TMR_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign terminal = (count_r == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/coin_accumulator.sv
// Turns coin strobes into a capped running credit, with refund on request or
// inactivity and clearing when downstream consumes the credit.
module coin_accumulator
  import vm_pkg::*;
#(
  parameter int MAX_CREDIT     = 60,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 10
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               i_coin_valid,
  input  logic [1:0]         i_coin,
  input  logic               i_refund,
  input  logic               i_consume,
  output logic [MONEY_W-1:0] o_credit,
  output logic               o_credit_valid,
  output logic               o_coin_reject,
  output logic               o_refund_valid,
  output logic [MONEY_W-1:0] o_refund_amt
);

  acc_state_t         state_r;
  acc_state_t         state_next_s;
  logic [MONEY_W-1:0] credit_r;
  logic [MONEY_W-1:0] credit_next_s;
  logic [MONEY_W-1:0] coin_val_s;
  logic [SUM_W-1:0]   sum_s;
  logic               coin_ok_s;
  logic               accept_s;
  logic               reject_s;
  logic               tmr_clear_s;
  logic               tmr_enable_s;
  logic               tmr_terminal_s;
  logic               credit_valid_r;
  logic               coin_reject_r;
  logic               refund_valid_r;
  logic [MONEY_W-1:0] refund_amt_r;

  // Coin admissibility independent of state; the sum is one bit wider so it cannot wrap.
  always_comb begin
    coin_val_s = coin_value(i_coin);
    sum_s      = {1'b0, credit_r} + {1'b0, coin_val_s};
    coin_ok_s  = i_coin_valid && (i_coin != COIN_NONE) && !i_consume &&
                 (sum_s <= SUM_W'(MAX_CREDIT));
  end

  // Next state and credit; in COLLECT consume beats refund beats coin beats timeout.
  always_comb begin
    state_next_s  = state_r;
    credit_next_s = credit_r;
    accept_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (coin_ok_s) begin
          accept_s      = 1'b1;
          credit_next_s = sum_s[MONEY_W-1:0];
          state_next_s  = ST_COLLECT;
        end else begin
          credit_next_s = {MONEY_W{1'b0}};
          state_next_s  = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (i_consume) begin
          credit_next_s = {MONEY_W{1'b0}};
          state_next_s  = ST_IDLE;
        end else if (i_refund) begin
          state_next_s  = ST_REFUND;
        end else if (coin_ok_s) begin
          accept_s      = 1'b1;
          credit_next_s = sum_s[MONEY_W-1:0];
        end else if (tmr_terminal_s) begin
          state_next_s  = ST_REFUND;
        end else begin
          state_next_s  = ST_COLLECT;
        end
      end
      ST_REFUND: begin
        credit_next_s = {MONEY_W{1'b0}};
        state_next_s  = ST_IDLE;
      end
      default: begin
        credit_next_s = {MONEY_W{1'b0}};
        state_next_s  = ST_IDLE;
      end
    endcase
  end

  // Any strobe not accepted is rejected; the timer only runs across idle COLLECT cycles.
  always_comb begin
    reject_s     = i_coin_valid && !accept_s;
    tmr_clear_s  = accept_s || (state_next_s != ST_COLLECT);
    tmr_enable_s = (state_r == ST_COLLECT);
  end

  vm_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_idle_timer (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .clear    (tmr_clear_s),
    .enable   (tmr_enable_s),
    .terminal (tmr_terminal_s)
  );

  // State, credit and Moore outputs registered together from the next-state values.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_r        <= ST_IDLE;
      credit_r       <= {MONEY_W{1'b0}};
      credit_valid_r <= 1'b0;
      coin_reject_r  <= 1'b0;
      refund_valid_r <= 1'b0;
      refund_amt_r   <= {MONEY_W{1'b0}};
    end else begin
      state_r        <= state_next_s;
      credit_r       <= credit_next_s;
      credit_valid_r <= (state_next_s == ST_COLLECT);
      coin_reject_r  <= reject_s;
      refund_valid_r <= (state_next_s == ST_REFUND);
      refund_amt_r   <= (state_next_s == ST_REFUND) ? credit_next_s : {MONEY_W{1'b0}};
    end
  end

  assign o_credit       = credit_r;
  assign o_credit_valid = credit_valid_r;
  assign o_coin_reject  = coin_reject_r;
  assign o_refund_valid = refund_valid_r;
  assign o_refund_amt   = refund_amt_r;

endmodule

// File: tb/tb_coin_accumulator.sv
// Self-checking bench for coin_accumulator: directed scenarios plus random
// traffic against a transaction-level credit model.
module tb_coin_accumulator;

  localparam int MAXC = 60;
  localparam int TMO  = 8;
  localparam int P_IDLE = 0;
  localparam int P_COL  = 1;
  localparam int P_REF  = 2;

  logic       i_clk = 1'b0;
  logic       i_resetn;
  logic       i_coin_valid;
  logic [1:0] i_coin;
  logic       i_refund;
  logic       i_consume;
  logic [5:0] o_credit;
  logic       o_credit_valid;
  logic       o_coin_reject;
  logic       o_refund_valid;
  logic [5:0] o_refund_amt;

  int checks = 0;
  int errors = 0;

  // Reference model: phase, credit and the edge index of the last accepted coin.
  int m_phase;
  int m_credit;
  int m_last;
  int m_edge;
  bit m_rej;

  always #5 i_clk = ~i_clk;

  coin_accumulator #(
    .MAX_CREDIT     (MAXC),
    .TIMEOUT_CYCLES (TMO),
    .TMR_W          (4)
  ) dut (
    .i_clk          (i_clk),
    .i_resetn       (i_resetn),
    .i_coin_valid   (i_coin_valid),
    .i_coin         (i_coin),
    .i_refund       (i_refund),
    .i_consume      (i_consume),
    .o_credit       (o_credit),
    .o_credit_valid (o_credit_valid),
    .o_coin_reject  (o_coin_reject),
    .o_refund_valid (o_refund_valid),
    .o_refund_amt   (o_refund_amt)
  );

  function automatic int value_of(input logic [1:0] c);
    int v;
    if (c == 2'd1) v = 5;
    else if (c == 2'd2) v = 10;
    else if (c == 2'd3) v = 25;
    else v = 0;
    return v;
  endfunction

  // Packed {credit, credit_valid, reject, refund_valid, refund_amt}.
  function automatic logic [14:0] expected();
    logic [5:0] amt;
    amt = (m_phase == P_REF) ? 6'(m_credit) : 6'd0;
    return {6'(m_credit), (m_phase == P_COL), m_rej, (m_phase == P_REF), amt};
  endfunction

  function automatic logic [14:0] observed();
    return {o_credit, o_credit_valid, o_coin_reject, o_refund_valid, o_refund_amt};
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_credit = 0; m_last = 0; m_edge = 0; m_rej = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int v;
    bit s;
    m_edge++;
    v = value_of(i_coin);
    s = i_coin_valid;
    m_rej = 1'b0;
    if (m_phase == P_IDLE) begin
      if (s && v > 0 && !i_consume) begin
        m_credit = v; m_phase = P_COL; m_last = m_edge;
      end else m_rej = s;
    end else if (m_phase == P_COL) begin
      if (i_consume) begin
        m_credit = 0; m_phase = P_IDLE; m_rej = s;
      end else if (i_refund) begin
        m_phase = P_REF; m_rej = s;
      end else if (s && v > 0 && m_credit + v <= MAXC) begin
        m_credit += v; m_last = m_edge;
      end else begin
        m_rej = s;
        if (m_edge - m_last == TMO) m_phase = P_REF;
      end
    end else begin
      m_rej = s; m_credit = 0; m_phase = P_IDLE;
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] c, input logic r, input logic k);
    i_coin_valid = v; i_coin = c; i_refund = r; i_consume = k;
    model_step();
    @(posedge i_clk); #1;
    i_coin_valid = 1'b0; i_coin = 2'd0; i_refund = 1'b0; i_consume = 1'b0;
  endtask

  task automatic test_reset();
    i_resetn = 1'b0; i_coin_valid = 1'b0; i_coin = 2'd0; i_refund = 1'b0; i_consume = 1'b0;
    model_reset();
    #12;
    checks++;
    if (observed() !== 15'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", observed());
    end
    i_resetn = 1'b1;
    cyc(1'b0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (observed() !== expected()) begin
      errors++; $display("FAIL reset_idle: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_accumulate();
    int want [3] = '{10, 35, 60};
    logic [1:0] codes [3] = '{2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, codes[i], 1'b0, 1'b0);
      checks++;
      if (o_credit !== 6'(want[i]) || o_credit_valid !== 1'b1 || o_coin_reject !== 1'b0) begin
        errors++; $display("FAIL accumulate_%0d: credit %0d cv %b rej %b want %0d 1 0",
                           i, o_credit, o_credit_valid, o_coin_reject, want[i]);
      end
    end
    cyc(1'b1, 2'd1, 1'b0, 1'b0);
    checks++;
    if (o_coin_reject !== 1'b1 || o_credit !== 6'd60 || observed() !== expected()) begin
      errors++; $display("FAIL cap_reject: rej %b credit %0d want 1 60", o_coin_reject, o_credit);
    end
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    cyc(1'b1, 2'd2, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 1'b0, 1'b0);
    checks++;
    if (o_coin_reject !== 1'b1 || o_credit !== 6'd10 || observed() !== expected()) begin
      errors++; $display("FAIL invalid_code: rej %b credit %0d want 1 10", o_coin_reject, o_credit);
    end
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic test_refund();
    cyc(1'b1, 2'd2, 1'b0, 1'b0);
    cyc(1'b1, 2'd3, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b1, 1'b0);
    checks++;
    if (o_refund_valid !== 1'b1 || o_refund_amt !== 6'd35 || observed() !== expected()) begin
      errors++; $display("FAIL refund_pulse: rv %b amt %0d want 1 35", o_refund_valid, o_refund_amt);
    end
    cyc(1'b1, 2'd1, 1'b0, 1'b0);
    checks++;
    if (o_credit !== 6'd0 || o_credit_valid !== 1'b0 || o_refund_valid !== 1'b0 ||
        o_coin_reject !== 1'b1) begin
      errors++; $display("FAIL refund_after: credit %0d cv %b rv %b rej %b want 0 0 0 1",
                         o_credit, o_credit_valid, o_refund_valid, o_coin_reject);
    end
    cyc(1'b1, 2'd3, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b1, 1'b0);
    checks++;
    if (o_coin_reject !== 1'b1 || o_refund_amt !== 6'd25 || observed() !== expected()) begin
      errors++; $display("FAIL refund_with_coin: rej %b amt %0d want 1 25", o_coin_reject, o_refund_amt);
    end
    cyc(1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    cyc(1'b1, 2'd2, 1'b0, 1'b0);
    for (int i = 1; i <= TMO; i++) begin
      cyc(1'b0, 2'd0, 1'b0, 1'b0);
      checks++;
      if (o_refund_valid !== (i == TMO) || (i == TMO && o_refund_amt !== 6'd10)) begin
        errors++; $display("FAIL timeout_edge_%0d: rv %b amt %0d want %b 10",
                           i, o_refund_valid, o_refund_amt, (i == TMO));
      end
    end
    cyc(1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 1'b0, 1'b0);
    for (int i = 1; i <= TMO; i++) begin
      cyc(1'b0, 2'd0, 1'b0, 1'b0);
      checks++;
      if (o_refund_valid !== (i == TMO) || observed() !== expected()) begin
        errors++; $display("FAIL timeout_restart_%0d: got %h want %h", i, observed(), expected());
      end
    end
    checks++;
    if (o_refund_amt !== 6'd15) begin
      errors++; $display("FAIL timeout_restart_amt: got %0d want 15", o_refund_amt);
    end
    cyc(1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_consume_coin();
    cyc(1'b1, 2'd3, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b0, 1'b1);
    checks++;
    if (o_credit !== 6'd0 || o_credit_valid !== 1'b0 || o_coin_reject !== 1'b1 ||
        o_refund_valid !== 1'b0) begin
      errors++; $display("FAIL consume_coin: credit %0d cv %b rej %b rv %b want 0 0 1 0",
                         o_credit, o_credit_valid, o_coin_reject, o_refund_valid);
    end
    cyc(1'b0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (o_refund_valid !== 1'b0 || observed() !== expected()) begin
      errors++; $display("FAIL consume_after: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 13; i++) begin
      cyc(1'b1, 2'd1, 1'b0, 1'b0);
      checks++;
      if (o_credit !== 6'((i > 12) ? 60 : 5 * i) || o_coin_reject !== (i > 12)) begin
        errors++; $display("FAIL b2b_%0d: credit %0d rej %b want %0d %b",
                           i, o_credit, o_coin_reject, (i > 12) ? 60 : 5 * i, (i > 12));
      end
    end
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 2'd3, 1'b0, 1'b0);
    #2 i_resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (observed() !== 15'd0) begin
      errors++; $display("FAIL async_reset: got %h want 0", observed());
    end
    #2 i_resetn = 1'b1;
    for (int i = 0; i < TMO + 2; i++) begin
      cyc(1'b0, 2'd0, 1'b0, 1'b0);
      checks++;
      if (o_refund_valid !== 1'b0 || observed() !== expected()) begin
        errors++; $display("FAIL reset_release_%0d: got %h want %h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 24) == 0), ($urandom_range(0, 29) == 0));
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL random_%0d: got %h want %h", i, observed(), expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_refund();
    test_timeout();
    test_consume_coin();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
